pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter register and next-PC sequencer for the single-cycle MIPS core.
//  Drives the PC incrementer's operands (pc, pc_inc) and registers its sum back as the sequential next PC.
//  Selects among sequential, branch and jump targets; handles fetch stalls and halt/resume.
//  Output pc addresses instruction memory directly.
// PARAMETERS
//  ADDR_W    5   PC / instruction address width; matches the incrementer width
//  RESET_PC  0   PC value loaded on reset
//  INC       1   constant increment driven on pc_inc (word-addressed imem)
// PORTS
//  clk            in   1       core clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  pc             out  ADDR_W  current PC; to imem address and incrementer operand a
//  pc_inc         out  ADDR_W  constant INC; to incrementer operand b
//  pc_next_seq    in   ADDR_W  incrementer sum (pc + pc_inc), combinational
//  branch_en      in   1       taken branch this cycle
//  branch_target  in   ADDR_W  branch destination
//  jump_en        in   1       jump this cycle
//  jump_target    in   ADDR_W  jump destination
//  stall          in   1       hold PC (hazard / external freeze)
//  imem_ready     in   1       imem can accept the address on pc this cycle
//  halt_req       in   1       enter HALT at next edge
//  resume         in   1       leave HALT
//  fetch_valid    out  1       pc is a valid fetch address this cycle
//  halted         out  1       state == HALT
//  wrap           out  1       one-cycle pulse: sequential advance wrapped to 0
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, fetch_valid=0, halted=0, wrap=0, pend_v=0.
//  States (2-bit): BOOT, RUN, WAIT, HALT.
//   BOOT: 1 cycle, fetch_valid=0, pc held; -> RUN unconditionally (halt_req ignored in BOOT).
//   RUN : fetch_valid=1. advance = imem_ready & ~stall.
//         halt_req -> HALT, pc held, pending redirect kept.
//         ~advance -> WAIT, pc held; a redirect arriving this cycle is latched into pend.
//         advance -> pc <= next (below), stay RUN.
//   WAIT: fetch_valid=1, pc held; new redirect overwrites pend (jump over branch).
//         halt_req -> HALT; advance -> RUN with pc <= next.
//   HALT: fetch_valid=0, halted=1, pc held, redirect inputs ignored; resume -> RUN next edge.
//         halt_req & resume same cycle in HALT: stay HALT.
//  Next-PC priority on an advancing edge: jump_en > branch_en > pend_v > pc_next_seq.
//   pend_v cleared on the edge that consumes it, or on a live redirect that supersedes it.
//  Latency: redirect seen at edge N appears on pc after edge N (same-cycle if advancing).
//  Width: all PC arithmetic modulo 2^ADDR_W; no carry out. wrap=1 for one cycle after an edge
//   where pc_next_seq was selected and pc_next_seq < pc (e.g. 31 -> 0). Never set on redirect.
//  pc_inc is constant INC at all times, including reset.
//  Reset mid-operation: all state cleared immediately; pend discarded.
//  Targets are not range-checked; any ADDR_W value is legal.
// STRUCTURE
//  Shared package (cpu_pkg): ADDR_W default, RESET_PC, INC, state encoding
//   localparams ST_BOOT=0, ST_RUN=1, ST_WAIT=2, ST_HALT=3.
//  One sub-module: pc_next_sel (combinational priority mux + wrap detect); FSM,
//   pc register and pend register live in pc_sequencer. Incrementer stays external.
// TESTING
//  1 Reset then free run, imem_ready=1: cycle after BOOT pc=0, then 1,2,3...; fetch_valid 0 in BOOT only.
//  2 Wrap: run from 0 to 31, next edge -> pc=0, wrap=1 for exactly one cycle, pc_inc=1 throughout.
//  3 Branch during stall: pc=6, stall=1 with branch_en target=20 -> pc stays 6 (WAIT); stall=0 -> pc=20.
//  4 Jump+branch same cycle at pc=4, jump_target=9, branch_target=15 -> pc=9.
//  5 halt_req at pc=12 -> HALT, halted=1, fetch_valid=0, pc=12 held 5 cycles despite jump_en; resume -> RUN, next advance pc=13.
//  6 rst_n low mid-WAIT with pend_v=1 -> pc=0 immediately, BOOT, pend cleared; after release pc goes 0,1,2.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: default widths, reset PC,
// increment constant and the sequencer state encoding.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int RESET_PC_DEF = 0;
    localparam int INC_DEF      = 1;

    // BOOT: one dead cycle after reset; RUN: fetching; WAIT: fetch held
    // by stall/imem; HALT: frozen until resume.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } seq_state_e;

    // True for the states in which the address on pc is a real fetch.
    function automatic logic is_fetch_state(seq_state_e s);
        return (s == ST_RUN) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the rest of the core: PC/incrementer
// operands, redirect requests, fetch handshake and halt control.
// slave  = the sequencer itself, master = the core/fetch side driving it.
interface pc_sequencer_if #(
    parameter int ADDR_W = pc_sequencer_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              stall;
    logic              imem_ready;
    logic              halt_req;
    logic              resume;
    logic              fetch_valid;
    logic              halted;
    logic              wrap;

    modport slave (
        output pc, pc_inc, fetch_valid, halted, wrap,
        input  pc_next_seq, branch_en, branch_target, jump_en, jump_target,
               stall, imem_ready, halt_req, resume
    );

    modport master (
        input  pc, pc_inc, fetch_valid, halted, wrap,
        output pc_next_seq, branch_en, branch_target, jump_en, jump_target,
               stall, imem_ready, halt_req, resume
    );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Next-PC priority mux: live jump, then live branch, then a redirect that
// was parked while fetch was held, then the incrementer's sequential sum.
// Also flags a sequential step that rolled over the top of the address space.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc_next_seq_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              pend_v_i,
    input  logic [ADDR_W-1:0] pend_pc_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              redirect_v_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              seq_sel_o,
    output logic              seq_wrap_o
);

    // Resolve the live redirect (jump beats branch), then pick the next PC.
    always_comb begin
        redirect_v_o  = jump_en_i | branch_en_i;
        redirect_pc_o = jump_en_i ? jump_target_i : branch_target_i;
        next_pc_o     = pc_next_seq_i;
        seq_sel_o     = 1'b0;
        if (redirect_v_o) begin
            next_pc_o = redirect_pc_o;
        end else if (pend_v_i) begin
            next_pc_o = pend_pc_i;
        end else begin
            next_pc_o = pc_next_seq_i;
            seq_sel_o = 1'b1;
        end
        seq_wrap_o = seq_sel_o & (pc_next_seq_i < pc_i);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer for the single-cycle core.
// Owns the PC, the parked-redirect register and the BOOT/RUN/WAIT/HALT FSM;
// the adder that forms pc + pc_inc lives outside and feeds pc_next_seq back.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int INC      = INC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pend_v_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              fetch_valid_q;
    logic              halted_q;
    logic              wrap_q;

    logic              advance;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect_v;
    logic [ADDR_W-1:0] redirect_pc;
    logic              seq_sel;
    logic              seq_wrap;

    assign advance = bus.imem_ready & ~bus.stall;

    pc_next_sel #(
        .ADDR_W(ADDR_W)
    ) u_next_sel (
        .pc_i           (pc_q),
        .pc_next_seq_i  (bus.pc_next_seq),
        .jump_en_i      (bus.jump_en),
        .jump_target_i  (bus.jump_target),
        .branch_en_i    (bus.branch_en),
        .branch_target_i(bus.branch_target),
        .pend_v_i       (pend_v_q),
        .pend_pc_i      (pend_pc_q),
        .next_pc_o      (next_pc),
        .redirect_v_o   (redirect_v),
        .redirect_pc_o  (redirect_pc),
        .seq_sel_o      (seq_sel),
        .seq_wrap_o     (seq_wrap)
    );

    // Sequencer FSM with PC, parked redirect and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC_V;
            pend_v_q      <= 1'b0;
            pend_pc_q     <= '0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= is_fetch_state(ST_RUN);
                    halted_q      <= 1'b0;
                end
                ST_RUN, ST_WAIT: begin
                    if (bus.halt_req) begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= is_fetch_state(ST_HALT);
                        halted_q      <= 1'b1;
                    end else if (!advance) begin
                        state_q       <= ST_WAIT;
                        fetch_valid_q <= is_fetch_state(ST_WAIT);
                        if (redirect_v) begin
                            pend_v_q  <= 1'b1;
                            pend_pc_q <= redirect_pc;
                        end
                    end else begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= is_fetch_state(ST_RUN);
                        pc_q          <= next_pc;
                        pend_v_q      <= 1'b0;
                        wrap_q        <= seq_sel & seq_wrap;
                    end
                end
                ST_HALT: begin
                    if (bus.resume && !bus.halt_req) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= is_fetch_state(ST_RUN);
                        halted_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_BOOT;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_inc      = INC_V;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.wrap        = wrap_q;

endmodule
